// File: rtl/ctrl_pipe.sv
// Control pipeline: ID/EX, EX/MEM and MEM/WB control registers, write-register select,
// branch redirect and bubble insertion. Optional load-use detection via CTRL_PIPE_HAZARD_EN.
module ctrl_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       regdst,
  input  logic       branch,
  input  logic       memread,
  input  logic       memtoreg,
  input  logic       memwrite,
  input  logic       alusrc,
  input  logic       regwrite,
  input  logic [2:0] aluop,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       stall_in,
  input  logic       zero_in,
  output logic       ex_regdst,
  output logic       ex_alusrc,
  output logic       ex_valid,
  output logic [2:0] ex_aluop,
  output logic [4:0] ex_rs,
  output logic [4:0] ex_rt,
  output logic [4:0] ex_rd,
  output logic       mem_branch,
  output logic       mem_memread,
  output logic       mem_memwrite,
  output logic       mem_valid,
  output logic [4:0] mem_wreg,
  output logic       wb_memtoreg,
  output logic       wb_regwrite,
  output logic       wb_valid,
  output logic [4:0] wb_wreg,
  output logic       pcsrc,
  output logic       stall_out
);

  logic       idex_regdst, idex_branch, idex_memread, idex_memtoreg;
  logic       idex_memwrite, idex_alusrc, idex_regwrite, idex_valid;
  logic [2:0] idex_aluop;
  logic [4:0] idex_rs, idex_rt, idex_rd;

  logic       exmem_branch, exmem_memread, exmem_memwrite, exmem_memtoreg;
  logic       exmem_regwrite, exmem_valid;
  logic [4:0] exmem_wreg;

  logic       memwb_memtoreg, memwb_regwrite, memwb_valid;
  logic [4:0] memwb_wreg;

  logic       ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic       mem_memtoreg, mem_regwrite;
  logic       hazard;
  logic       idex_bubble;

  // Invalid stages present all-zero controls, whatever the register holds.
  assign ex_valid     = idex_valid;
  assign ex_regdst    = idex_valid & idex_regdst;
  assign ex_alusrc    = idex_valid & idex_alusrc;
  assign ex_aluop     = idex_valid ? idex_aluop : 3'b000;
  assign ex_rs        = idex_valid ? idex_rs : 5'd0;
  assign ex_rt        = idex_valid ? idex_rt : 5'd0;
  assign ex_rd        = idex_valid ? idex_rd : 5'd0;
  assign ex_branch    = idex_valid & idex_branch;
  assign ex_memread   = idex_valid & idex_memread;
  assign ex_memwrite  = idex_valid & idex_memwrite;
  assign ex_memtoreg  = idex_valid & idex_memtoreg;
  assign ex_regwrite  = idex_valid & idex_regwrite;

  assign mem_valid    = exmem_valid;
  assign mem_branch   = exmem_valid & exmem_branch;
  assign mem_memread  = exmem_valid & exmem_memread;
  assign mem_memwrite = exmem_valid & exmem_memwrite;
  assign mem_memtoreg = exmem_valid & exmem_memtoreg;
  assign mem_regwrite = exmem_valid & exmem_regwrite;
  assign mem_wreg     = exmem_valid ? exmem_wreg : 5'd0;

  assign wb_valid     = memwb_valid;
  assign wb_memtoreg  = memwb_valid & memwb_memtoreg;
  assign wb_regwrite  = memwb_valid & memwb_regwrite;
  assign wb_wreg      = memwb_valid ? memwb_wreg : 5'd0;

  assign pcsrc = mem_valid & mem_branch & zero_in;

`ifdef CTRL_PIPE_HAZARD_EN
  assign hazard = idex_valid & idex_memread & id_valid & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));
`else
  assign hazard = 1'b0;
`endif

  // A taken branch must not let upstream hold a wrong-path instruction.
  assign stall_out   = (stall_in | hazard) & ~pcsrc;
  assign idex_bubble = pcsrc | stall_out | ~id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_regdst   <= 1'b0;
      idex_branch   <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memtoreg <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_alusrc   <= 1'b0;
      idex_regwrite <= 1'b0;
      idex_valid    <= 1'b0;
      idex_aluop    <= 3'b000;
      idex_rs       <= 5'd0;
      idex_rt       <= 5'd0;
      idex_rd       <= 5'd0;
    end else if (idex_bubble) begin
      idex_regdst   <= 1'b0;
      idex_branch   <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memtoreg <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_alusrc   <= 1'b0;
      idex_regwrite <= 1'b0;
      idex_valid    <= 1'b0;
      idex_aluop    <= 3'b000;
      idex_rs       <= 5'd0;
      idex_rt       <= 5'd0;
      idex_rd       <= 5'd0;
    end else begin
      idex_regdst   <= regdst;
      idex_branch   <= branch;
      idex_memread  <= memread;
      idex_memtoreg <= memtoreg;
      idex_memwrite <= memwrite;
      idex_alusrc   <= alusrc;
      idex_regwrite <= regwrite;
      idex_valid    <= 1'b1;
      idex_aluop    <= aluop;
      idex_rs       <= id_rs;
      idex_rt       <= id_rt;
      idex_rd       <= id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || pcsrc) begin
      exmem_branch   <= 1'b0;
      exmem_memread  <= 1'b0;
      exmem_memwrite <= 1'b0;
      exmem_memtoreg <= 1'b0;
      exmem_regwrite <= 1'b0;
      exmem_valid    <= 1'b0;
      exmem_wreg     <= 5'd0;
    end else begin
      exmem_branch   <= ex_branch;
      exmem_memread  <= ex_memread;
      exmem_memwrite <= ex_memwrite;
      exmem_memtoreg <= ex_memtoreg;
      exmem_regwrite <= ex_regwrite;
      exmem_valid    <= ex_valid;
      exmem_wreg     <= ex_regdst ? ex_rd : ex_rt;
    end
  end

  // The branch itself still retires into WB even while it flushes younger stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memwb_memtoreg <= 1'b0;
      memwb_regwrite <= 1'b0;
      memwb_valid    <= 1'b0;
      memwb_wreg     <= 5'd0;
    end else begin
      memwb_memtoreg <= mem_memtoreg;
      memwb_regwrite <= mem_regwrite;
      memwb_valid    <= mem_valid;
      memwb_wreg     <= mem_wreg;
    end
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Control-signal pipeline that receives the decoded control bundle produced in ID (regdst, branch, memread, memtoreg, aluop, memwrite, alusrc, regwrite) and delivers each signal to the stage that consumes it (EX, MEM or WB) in the 5-stage MIPS datapath. It also carries the instruction's register fields and resolves the write-back register number. It generates the branch redirect from MEM, and inserts bubbles on stall or flush. It is the consuming end of the main control decoder's output interface.

## Interface
- No parameters; register numbers fixed at 5 bits, aluop fixed at 3 bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite  input  1 each  ID-stage control bundle
- aluop  input  3  ID-stage ALU operation class
- id_valid  input  1  ID holds a real instruction
- id_rs, id_rt, id_rd  input  5 each  instruction register fields
- stall_in  input  1  external request: bubble into EX this cycle
- zero_in  input  1  ALU zero flag of the instruction in MEM
- ex_regdst, ex_alusrc, ex_valid  output  1  EX-stage controls
- ex_aluop  output  3
- ex_rs, ex_rt, ex_rd  output  5
- mem_branch, mem_memread, mem_memwrite, mem_valid  output  1
- mem_wreg  output  5  resolved destination register
- wb_memtoreg, wb_regwrite, wb_valid  output  1
- wb_wreg  output  5
- pcsrc  output  1  branch taken in MEM (combinational)
- stall_out  output  1  hold PC and IF/ID (combinational)

## Operation
- Three register stages: ID/EX, EX/MEM, MEM/WB. Each has a valid bit.
- ID/EX captures the full bundle, id_valid, id_rs, id_rt and id_rd.
- EX/MEM captures branch, memread, memwrite, memtoreg and regwrite. It also captures mem_wreg = ex_regdst ? ex_rd : ex_rt.
- MEM/WB captures memtoreg, regwrite and wreg.
- Bubble = all control bits 0, valid 0, register fields 0.
- Gating: any stage with valid=0 drives its control outputs as 0. This holds even if stale bits remain in the register.
- pcsrc = mem_valid & mem_branch & zero_in.
- Flush (pcsrc=1 at an edge): ID/EX and EX/MEM load bubbles. MEM/WB loads the branch's own MEM contents normally.
- Stall (stall_out=1 at an edge): ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
- stall_out = stall_in | hazard.
  - hazard = 0 unless CTRL_PIPE_HAZARD_EN is defined.
  - stall_out is forced to 0 while pcsrc=1.
- Simultaneous flush and stall: flush wins and the result is a bubble. stall_out=0 that cycle, so the upstream stages do not hold a wrong-path instruction.
- id_valid=0 is equivalent to a bubble entering ID/EX.

## Timing
- Reset (asynchronous assert; synchronous-release assumption): every output register is 0. Consequently pcsrc=0 and stall_out reflects stall_in only.
- Latency from ID inputs:
  - EX outputs: 1 cycle.
  - MEM outputs: 2 cycles.
  - WB outputs: 3 cycles.
- pcsrc and stall_out are combinational within the cycle. They have no registered delay.
- Reset asserted mid-operation clears all stages immediately. No partial instruction survives.
- No back-pressure exists on the WB side; WB outputs are valid for exactly one cycle per instruction.

## Configuration
- Macro: CTRL_PIPE_HAZARD_EN.
- Defined: load-use detection is compiled in.
  - hazard = ex_valid & ex_memread_internal & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
  - ex_memread_internal is the ID/EX copy of memread.
  - hazard bubbles EX and asserts stall_out for exactly one cycle per load-use pair.
- Not defined: hazard is tied to 0. Stalls come only from stall_in. The ID/EX memread bit is still carried.

## Test plan
- R-type (regdst=1, regwrite=1, aluop=000, rd=5, rt=3) issued at cycle 0:
  - cycle 1: ex_regdst=1, ex_aluop=000.
  - cycle 2: mem_wreg=5.
  - cycle 3: wb_regwrite=1, wb_wreg=5; wb_valid high for one cycle only.
- lw (memread=1, memtoreg=1, alusrc=1, regwrite=1, regdst=0, rt=8):
  - mem_memread=1 at cycle 2.
  - wb_memtoreg=1 and wb_wreg=8 at cycle 3.
- beq at cycle 0 with zero_in=1 at cycle 2:
  - pcsrc=1 in cycle 2.
  - The two younger instructions never reach MEM/WB with valid=1.
  - With zero_in=0, both younger instructions complete normally.
- stall_in=1 for one cycle with a sw in ID:
  - EX shows a bubble (all 0) for that cycle.
  - sw reappears in EX one cycle later when ID is held upstream.
  - stall_in and pcsrc both high: pcsrc=1, stall_out=0, EX bubble.
- With CTRL_PIPE_HAZARD_EN: lw rt=8 followed by add rs=8:
  - stall_out=1 for exactly one cycle and EX bubble.
  - With ex_rt=0, or without the macro, stall_out=0.
- rst pulsed while three valid instructions are in flight: all outputs 0 immediately; first post-reset instruction propagates normally.
